// File: rtl/encoder_sequencer.sv
// Sequential priority encoder: captures a request vector and hands out the
// index of each set bit, one per ready/valid transfer, then pulses done.
module encoder_sequencer #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned HIGH_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] req_in,
  output logic [IDX_W-1:0] out,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] pending,
  output logic [IDX_W:0]   count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] next_out;
  logic             next_valid;
  logic             next_done;
  logic [WIDTH-1:0] next_pending;
  logic [IDX_W:0]   next_count;
  logic [WIDTH-1:0] clear_mask;
  logic [WIDTH-1:0] remaining;

  // Scan in the direction that leaves the winning bit as the last match.
  function automatic logic [IDX_W-1:0] prio_idx(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (HIGH_FIRST != 0) begin
        if (v[i]) idx = IDX_W'(i);
      end else begin
        if (v[WIDTH-1-i]) idx = IDX_W'(WIDTH-1-i);
      end
    end
    return idx;
  endfunction

  always_comb begin
    clear_mask      = '0;
    clear_mask[out] = 1'b1;
    remaining       = pending & ~clear_mask;
  end

  always_comb begin
    next_state   = state;
    next_out     = out;
    next_valid   = valid;
    next_done    = 1'b0;
    next_pending = pending;
    next_count   = count;
    case (state)
      IDLE: begin
        if (load) begin
          next_pending = req_in;
          next_count   = '0;
          if (req_in != '0) begin
            next_out   = prio_idx(req_in);
            next_valid = 1'b1;
            next_state = SERVE;
          end else begin
            next_state = FINISH;
            next_done  = 1'b1;
          end
        end
      end
      SERVE: begin
        if (valid && ready) begin
          next_pending = remaining;
          next_count   = count + (IDX_W+1)'(1);
          if (remaining != '0) begin
            next_out = prio_idx(remaining);
          end else begin
            next_valid = 1'b0;
            next_state = FINISH;
            next_done  = 1'b1;
          end
        end
      end
      FINISH: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        next_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      out     <= '0;
      valid   <= 1'b0;
      done    <= 1'b0;
      pending <= '0;
      count   <= '0;
    end else if (enable) begin
      state   <= next_state;
      out     <= next_out;
      valid   <= next_valid;
      done    <= next_done;
      pending <= next_pending;
      count   <= next_count;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_encoder_sequencer.sv
// Scoreboard bench for encoder_sequencer: stimulus pushes expected indices,
// per-instance monitors pop and compare on every accepted transfer.
module tb_encoder_sequencer;

  logic        clk = 1'b0;
  logic        reset;

  logic        en0, load0, rdy0;
  logic [15:0] req0;
  logic [3:0]  out0;
  logic        valid0, busy0, done0;
  logic [15:0] pend0;
  logic [4:0]  cnt0;

  logic        en1, load1, rdy1;
  logic [15:0] req1;
  logic [3:0]  out1;
  logic        valid1, busy1, done1;
  logic [15:0] pend1;
  logic [4:0]  cnt1;

  int checks = 0;
  int errors = 0;

  logic [3:0]  q0[$];
  logic [3:0]  q1[$];
  logic [15:0] mp0 = '0;
  logic [15:0] mp1 = '0;

  always #5 clk = ~clk;

  encoder_sequencer #(.WIDTH(16), .IDX_W(4), .HIGH_FIRST(0)) dut0 (
    .clk(clk), .reset(reset), .enable(en0), .load(load0), .req_in(req0),
    .out(out0), .valid(valid0), .ready(rdy0), .busy(busy0), .done(done0),
    .pending(pend0), .count(cnt0)
  );

  encoder_sequencer #(.WIDTH(16), .IDX_W(4), .HIGH_FIRST(1)) dut1 (
    .clk(clk), .reset(reset), .enable(en1), .load(load1), .req_in(req1),
    .out(out1), .valid(valid1), .ready(rdy1), .busy(busy1), .done(done1),
    .pending(pend1), .count(cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: a transfer happens at the next rising edge when these hold.
  always @(negedge clk) begin
    if (!reset && en0 && valid0 && rdy0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0_unexpected_transfer: got %0d expected none", out0);
      end else begin
        logic [3:0] e;
        e = q0.pop_front();
        chk("dut0_out", 32'(out0), 32'(e));
        mp0[e] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && en1 && valid1 && rdy1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected_transfer: got %0d expected none", out1);
      end else begin
        logic [3:0] e;
        e = q1.pop_front();
        chk("dut1_out", 32'(out1), 32'(e));
        mp1[e] = 1'b0;
      end
    end
  end

  // Runs cycles from a load edge until done; checks pending/out against the
  // model each cycle and the exact number of edges until done appears.
  task automatic wait_done(input bit d, input int exp_n, input bit inject, input bit toggle);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        load0 = 1'b0;
        load1 = 1'b0;
      end
      if ((d ? done1 : done0) == 1'b1) begin
        seen = 1'b1;
      end else if (d == 1'b0) begin
        chk("dut0_pending_model", 32'(pend0), 32'(mp0));
        if (valid0 && q0.size() > 0) chk("dut0_out_hold", 32'(out0), 32'(q0[0]));
      end else begin
        chk("dut1_pending_model", 32'(pend1), 32'(mp1));
        if (valid1 && q1.size() > 0) chk("dut1_out_hold", 32'(out1), 32'(q1[0]));
      end
      if (toggle) rdy0 = (n % 3 == 0);
      if (inject && n == 5) begin
        load1 = 1'b1;
        req1  = 16'h0001;
      end
      if (inject && n == 6) load1 = 1'b0;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done expected done within 60 cycles");
    end else begin
      chk("done_latency", 32'(n), 32'(exp_n));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    en0 = 1'b1; load0 = 1'b0; rdy0 = 1'b0; req0 = '0;
    en1 = 1'b1; load1 = 1'b0; rdy1 = 1'b0; req1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 32'(out0), 0);
    chk("rst_valid", 32'(valid0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_pending", 32'(pend0), 0);
    chk("rst_count", 32'(cnt0), 0);
    @(negedge clk);
    reset = 1'b0;

    // 1: empty load
    @(posedge clk); #1;
    load0 = 1'b1; req0 = 16'h0000; mp0 = 16'h0000;
    wait_done(1'b0, 1, 1'b0, 1'b0);
    chk("t1_valid", 32'(valid0), 0);
    chk("t1_busy_finish", 32'(busy0), 1);
    @(posedge clk); #1;
    chk("t1_done_clear", 32'(done0), 0);
    chk("t1_busy", 32'(busy0), 0);
    chk("t1_count", 32'(cnt0), 0);

    // 2: low-first, ready held high from the load cycle
    load0 = 1'b1; req0 = 16'b1000_0000_0010_0101; rdy0 = 1'b1; mp0 = req0;
    q0.push_back(4'd0); q0.push_back(4'd2); q0.push_back(4'd5); q0.push_back(4'd15);
    wait_done(1'b0, 5, 1'b0, 1'b0);
    chk("t2_count", 32'(cnt0), 4);
    chk("t2_pending", 32'(pend0), 0);
    chk("t2_valid", 32'(valid0), 0);
    chk("t2_queue_empty", 32'(q0.size()), 0);
    @(posedge clk); #1;
    chk("t2_done_pulse", 32'(done0), 0);
    chk("t2_busy", 32'(busy0), 0);

    // 3: same vector, ready pattern 1,0,0 repeating
    load0 = 1'b1; req0 = 16'b1000_0000_0010_0101; rdy0 = 1'b1; mp0 = req0;
    q0.push_back(4'd0); q0.push_back(4'd2); q0.push_back(4'd5); q0.push_back(4'd15);
    wait_done(1'b0, 13, 1'b0, 1'b1);
    chk("t3_count", 32'(cnt0), 4);
    chk("t3_queue_empty", 32'(q0.size()), 0);
    rdy0 = 1'b0;
    @(posedge clk); #1;

    // 4: high-first all-ones, with an ignored load mid-sequence
    load1 = 1'b1; req1 = 16'hFFFF; rdy1 = 1'b1; mp1 = 16'hFFFF;
    for (int i = 15; i >= 0; i--) q1.push_back(4'(i));
    wait_done(1'b1, 17, 1'b1, 1'b0);
    chk("t4_count", 32'(cnt1), 16);
    chk("t4_pending", 32'(pend1), 0);
    chk("t4_queue_empty", 32'(q1.size()), 0);
    @(posedge clk); #1;
    chk("t4_busy", 32'(busy1), 0);
    rdy1 = 1'b0;

    // 5: asynchronous reset mid-sequence
    load0 = 1'b1; req0 = 16'h00F0; rdy0 = 1'b0; mp0 = 16'h00F0;
    q0.push_back(4'd4);
    @(posedge clk); #1;
    load0 = 1'b0;
    chk("t5_first_out", 32'(out0), 4);
    rdy0 = 1'b1;
    @(posedge clk); #1;
    rdy0 = 1'b0;
    chk("t5_count1", 32'(cnt0), 1);
    #2;
    reset = 1'b1;
    mp0 = '0;
    #1;
    chk("t5_rst_out", 32'(out0), 0);
    chk("t5_rst_valid", 32'(valid0), 0);
    chk("t5_rst_busy", 32'(busy0), 0);
    chk("t5_rst_pending", 32'(pend0), 0);
    chk("t5_rst_count", 32'(cnt0), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("t5_no_done", 32'(done0), 0);
    end
    load0 = 1'b1; req0 = 16'h0001; mp0 = 16'h0001;
    q0.push_back(4'd0);
    @(posedge clk); #1;
    load0 = 1'b0;
    chk("t5_reload_out", 32'(out0), 0);
    chk("t5_reload_valid", 32'(valid0), 1);
    rdy0 = 1'b1;
    wait_done(1'b0, 1, 1'b0, 1'b0);
    chk("t5_count", 32'(cnt0), 1);
    rdy0 = 1'b0;
    @(posedge clk); #1;

    // 6: enable held low with ready high
    load0 = 1'b1; req0 = 16'h0300; mp0 = 16'h0300;
    @(posedge clk); #1;
    load0 = 1'b0;
    en0 = 1'b0; rdy0 = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t6_hold_out", 32'(out0), 8);
      chk("t6_hold_valid", 32'(valid0), 1);
      chk("t6_hold_count", 32'(cnt0), 0);
      chk("t6_hold_pending", 32'(pend0), 16'h0300);
    end
    q0.push_back(4'd8); q0.push_back(4'd9);
    en0 = 1'b1;
    wait_done(1'b0, 2, 1'b0, 1'b0);
    chk("t6_count", 32'(cnt0), 2);
    chk("t6_queue_empty", 32'(q0.size()), 0);
    rdy0 = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
